// File: rtl/axis_pkt_buf_pkg.sv
// Shared types and constants for the AXI-Stream packet buffer.
//   master_state_t : output-side packet FSM states
//   NULL_STRB      : all-zero strobe pattern (slice to the bus strobe width)
//   beat_bits()    : stored beat width (tdata + tstrb + tlast) for a data width
package axis_pkt_buf_pkg;

   typedef enum logic [1:0] {
      M_IDLE  = 2'd0,
      M_PKT   = 2'd1,
      M_FLUSH = 2'd2
   } master_state_t;

   localparam int unsigned MAX_STRB_W = 128;
   localparam logic [MAX_STRB_W-1:0] NULL_STRB = '0;

   function automatic int unsigned beat_bits(input int unsigned data_width);
      return data_width + data_width / 8 + 1;
   endfunction

endpackage

// File: rtl/axis_pkt_buf_if.sv
// AXI-Stream bus bundle.
//   master : drives tdata/tstrb/tvalid/tlast, receives tready
//   slave  : receives tdata/tstrb/tvalid/tlast, drives tready
interface axis_pkt_buf_if #(
   parameter int unsigned DATA_WIDTH = 32
) ();
   localparam int unsigned STRB_W = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] tdata;
   logic [STRB_W-1:0]     tstrb;
   logic                  tvalid;
   logic                  tlast;
   logic                  tready;

   modport master (output tdata, output tstrb, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tstrb, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_pkt_buf_ram.sv
// Beat storage: DEPTH x WIDTH, one synchronous write port, one asynchronous read port.
//   clk   : write clock
//   we    : write enable, waddr/wdata : write address/data
//   raddr : read address, rdata : combinational read data
// Contents are not reset.
module axis_pkt_buf_ram #(
   parameter int unsigned WIDTH = 37,
   parameter int unsigned DEPTH = 16,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/axis_packet_buffer.sv
// AXI-Stream packet buffer: circular FIFO of DEPTH beats between s_axis and m_axis.
//   axis_aclk, axis_areset : clock, asynchronous active-high reset
//   s_axis                 : producer side (slave modport)
//   m_axis                 : consumer side (master modport), first-word fall-through
//   occupancy              : beats stored, 0..DEPTH
//   pkt_count              : complete packets stored (store-and-forward only, else 0)
//   pkt_oversize           : sticky, a packet exceeded DEPTH (store-and-forward only, else 0)
// Build option: define AXIS_PKT_BUF_STORE_FWD_EN for store-and-forward; default is cut-through.
module axis_packet_buffer
   import axis_pkt_buf_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 16,
   localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
   input  logic              axis_aclk,
   input  logic              axis_areset,
   axis_pkt_buf_if.slave     s_axis,
   axis_pkt_buf_if.master    m_axis,
   output logic [ADDR_W:0]   occupancy,
   output logic [ADDR_W:0]   pkt_count,
   output logic              pkt_oversize
);
   localparam int unsigned STRB_W    = DATA_WIDTH / 8;
   localparam int unsigned BEAT_W    = beat_bits(DATA_WIDTH);
   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] tdata;
      logic [STRB_W-1:0]     tstrb;
      logic                  tlast;
   } beat_t;

   logic [ADDR_W:0] wr_ptr, rd_ptr, occ_next;
   logic            full, empty, null_beat, s_ready, wr_en, rd_en;
   logic            m_valid, release_ok, flush_go;
   beat_t           wr_beat, rd_beat;
   master_state_t   state;

   assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                  (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
   assign empty = (wr_ptr == rd_ptr);

   // Zero-strobe beats without tlast carry nothing; accept and drop them.
   assign null_beat = (s_axis.tstrb == NULL_STRB[STRB_W-1:0]) && !s_axis.tlast;
   assign wr_en     = s_axis.tvalid && s_ready && !null_beat;
   assign rd_en     = m_valid && m_axis.tready;

   assign wr_beat = '{tdata: s_axis.tdata, tstrb: s_axis.tstrb, tlast: s_axis.tlast};

   axis_pkt_buf_ram #(.WIDTH(BEAT_W), .DEPTH(DEPTH)) u_ram (
      .clk   (axis_aclk),
      .we    (wr_en),
      .waddr (wr_ptr[ADDR_W-1:0]),
      .wdata (wr_beat),
      .raddr (rd_ptr[ADDR_W-1:0]),
      .rdata (rd_beat)
   );

   // Output valid is a pure function of registered state, giving one-cycle write-to-read latency.
   always_comb begin
      m_valid = 1'b0;
      case (state)
         M_IDLE:  m_valid = release_ok;
         M_PKT:   m_valid = !empty;
         M_FLUSH: m_valid = !empty;
         default: m_valid = 1'b0;
      endcase
   end

   assign s_axis.tready = s_ready;
   assign m_axis.tvalid = m_valid;
   assign m_axis.tdata  = m_valid ? rd_beat.tdata : '0;
   assign m_axis.tstrb  = m_valid ? rd_beat.tstrb : '0;
   assign m_axis.tlast  = m_valid ? rd_beat.tlast : 1'b0;

   always_comb begin
      occ_next = occupancy;
      if (wr_en && !rd_en)      occ_next = occupancy + (ADDR_W + 1)'(1);
      else if (!wr_en && rd_en) occ_next = occupancy - (ADDR_W + 1)'(1);
   end

   // Pointers, occupancy and ready; ready looks ahead so a full FIFO never takes a write.
   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
         s_ready   <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (ADDR_W + 1)'(1);
         if (rd_en) rd_ptr <= rd_ptr + (ADDR_W + 1)'(1);
         occupancy <= occ_next;
         s_ready   <= (occ_next != DEPTH_CNT);
      end
   end

`ifdef AXIS_PKT_BUF_STORE_FWD_EN
   logic wr_last, rd_last;

   assign wr_last    = wr_en && s_axis.tlast;
   assign rd_last    = rd_en && rd_beat.tlast;
   assign release_ok = (pkt_count != '0);
   // Full with no complete packet can never release: drain it cut-through instead.
   assign flush_go   = full && (pkt_count == '0);

   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         pkt_count    <= '0;
         pkt_oversize <= 1'b0;
      end else begin
         if (wr_last && !rd_last)      pkt_count <= pkt_count + (ADDR_W + 1)'(1);
         else if (!wr_last && rd_last) pkt_count <= pkt_count - (ADDR_W + 1)'(1);
         if (flush_go) pkt_oversize <= 1'b1;
      end
   end
`else
   assign release_ok   = !empty;
   assign flush_go     = 1'b0;
   assign pkt_count    = '0;
   assign pkt_oversize = 1'b0;
`endif

   // Packet-position FSM: IDLE sits on a packet boundary, PKT/FLUSH are inside one.
   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         state <= M_IDLE;
      end else begin
         case (state)
            M_IDLE: begin
               if (rd_en)         state <= rd_beat.tlast ? M_IDLE : M_PKT;
               else if (flush_go) state <= M_FLUSH;
            end
            M_PKT, M_FLUSH: begin
               if (rd_en && rd_beat.tlast) state <= M_IDLE;
            end
            default: state <= M_IDLE;
         endcase
      end
   end
endmodule
